switch_debouncer: RTL

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer_if.sv | 27 ++
 rtl/switch_debouncer.sv | 95 +++++++++
 2 files changed

// File: rtl/switch_debouncer_if.sv
// Switch bundle between the board switch debouncer and its consumers.
// The master side drives the raw levels; the slave (debouncer) returns clean levels and edge pulses.
interface switch_debouncer_if #(
    parameter int number_switches = 18
);
    logic [number_switches-1:0] switches_raw;
    logic [number_switches-1:0] switches;
    logic [number_switches-1:0] rise;
    logic [number_switches-1:0] fall;
    logic                       changed;

    modport master (
        output switches_raw,
        input  switches,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  switches_raw,
        output switches,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/switch_debouncer.sv
// Per-switch synchronizer plus persistence-count debouncer for board slide switches.
// Define SWITCH_DEBOUNCE_EDGES_EN to build the rise/fall/changed pulse registers; otherwise they read 0.
module switch_debouncer #(
    parameter int number_switches = 18,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debouncer_if.slave  sw
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [number_switches-1:0] switches_vec;
    logic [number_switches-1:0] accept_vec;

    generate
        for (genvar gi = 0; gi < number_switches; gi++) begin : g_bit
            logic          s1_reg;
            logic          s2_reg;
            logic          level_reg;
            logic          level_next;
            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_next;
            logic          accept;

            // Any return of s2 to the accepted level wipes the run; a level is only
            // taken once it has differed for DEBOUNCE_CYCLES consecutive edges.
            always_comb begin
                accept     = 1'b0;
                count_next = count_reg;
                if (s2_reg == level_reg) begin
                    count_next = '0;
                end else if (count_reg == LAST_COUNT) begin
                    accept     = 1'b1;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CW'(1);
                end
                level_next = accept ? s2_reg : level_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    level_reg <= 1'b0;
                    count_reg <= '0;
                end else begin
                    s1_reg    <= sw.switches_raw[gi];
                    s2_reg    <= s1_reg;
                    level_reg <= level_next;
                    count_reg <= count_next;
                end
            end

            assign switches_vec[gi] = level_reg;
            assign accept_vec[gi]   = accept;
        end
    endgenerate

    assign sw.switches = switches_vec;

`ifdef SWITCH_DEBOUNCE_EDGES_EN
    logic [number_switches-1:0] rise_reg;
    logic [number_switches-1:0] fall_reg;
    logic                       changed_reg;

    // The direction of an accepted change is the opposite of the level being replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_reg    <= '0;
            fall_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            rise_reg    <= accept_vec & ~switches_vec;
            fall_reg    <= accept_vec &  switches_vec;
            changed_reg <= |accept_vec;
        end
    end

    assign sw.rise    = rise_reg;
    assign sw.fall    = fall_reg;
    assign sw.changed = changed_reg;
`else
    logic unused_accept;
    assign unused_accept = |accept_vec;

    assign sw.rise    = '0;
    assign sw.fall    = '0;
    assign sw.changed = 1'b0;
`endif

endmodule
